spi_stream_fifo: RTL and testbench
==================================

SPI_STREAM_FIFO -- requirements
Module: spi_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits.
REQ-002 SHALL have parameter BUFFER_DEPTH, default 4, meaning storage entries; any integer >= 2, power of two not required.
REQ-003 SHALL have parameter FALL_THROUGH, default 0, meaning 1 = empty-FIFO bypass enabled.
REQ-004 SHALL have derived parameter LOG_BUFFER_DEPTH = ceil(log2(BUFFER_DEPTH)), default from package function.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 clr_i  in  1  synchronous flush.
REQ-008 valid_i / data_i / ready_o  in / in / out  1 / DATA_WIDTH / 1  write-side handshake.
REQ-009 valid_o / data_o / ready_i  out / out / in  1 / DATA_WIDTH / 1  read-side handshake.
REQ-010 elements_o  out  LOG_BUFFER_DEPTH+1  stored word count.
REQ-011 afull_thr_i / aempty_thr_i  in  LOG_BUFFER_DEPTH+1 each  watermark thresholds.
REQ-012 almost_full_o / almost_empty_o  out  1 each  watermark flags.
REQ-013 overflow_o  out  1  sticky: push attempted while full.
REQ-014 drop_cnt_o  out  8  saturating count of dropped pushes.
REQ-015 err_clr_i  in  1  synchronous clear of overflow_o and drop_cnt_o.

Function
REQ-016 push = valid_i & ready_o; pop = valid_o & ready_i; ready_o = (elements != BUFFER_DEPTH), no combinational path from ready_i.
REQ-017 Pushed word SHALL be written to wr_ptr entry and visible on data_o one cycle later (FALL_THROUGH=0 or FIFO non-empty).
REQ-018 valid_o = (elements != 0) | (FALL_THROUGH & valid_i); data_o = stored head when elements != 0, else data_i (bypass).
REQ-019 Bypass case (FALL_THROUGH=1, empty, push & pop same cycle): word SHALL pass through, nothing stored, count and pointers unchanged.
REQ-020 Count: push only +1; pop only -1; push & pop together unchanged; never exceeds BUFFER_DEPTH or goes below 0.
REQ-021 Push and pop together while full SHALL NOT occur (ready_o=0); pop while full frees one entry, ready_o high next cycle.
REQ-022 wr_ptr/rd_ptr SHALL wrap from BUFFER_DEPTH-1 to 0 on advance.
REQ-023 valid_i & !ready_o SHALL drop data_i, set overflow_o next cycle, increment drop_cnt_o saturating at 255.
REQ-024 almost_full_o = (elements >= afull_thr_i); almost_empty_o = (elements <= aempty_thr_i); both combinational from count register.
REQ-025 clr_i SHALL zero count and pointers next cycle, taking priority over same-cycle push/pop (push discarded, not counted as drop); overflow_o/drop_cnt_o unaffected.
REQ-026 err_clr_i SHALL zero overflow_o and drop_cnt_o next cycle; a same-cycle drop event is lost (clear wins).
REQ-027 data_o is don't-care while valid_o = 0.

Reset
REQ-028 rst_ni low SHALL immediately force count, pointers, overflow_o, drop_cnt_o to 0: valid_o=FALL_THROUGH&valid_i, ready_o=1, almost_full_o=(afull_thr_i==0), almost_empty_o=1.
REQ-029 Storage array SHALL NOT be reset (RAM-inferable); reset mid-transfer discards all contents.

Structure
REQ-030 Package spi_fifo_pkg SHALL hold the clog2 helper function and drop-counter width constant (8).
REQ-031 One sub-module spi_fifo_ptr (wrapping pointer, parameter DEPTH, inputs clr/advance) SHALL be instantiated for wr_ptr and rd_ptr.

Verification (DATA_WIDTH=8, BUFFER_DEPTH=3, thresholds afull=2, aempty=0)
REQ-032 Push 0xA1,0xA2,0xA3 then pop 3 -> ready_o=0 after third push, elements_o=3, almost_full_o=1; pops return A1,A2,A3 in order, elements_o 2,1,0.
REQ-033 Five push/pop cycles across wrap (push 0x10..0x14, pop after 1 cycle each) -> output order 0x10..0x14, elements_o never > 2.
REQ-034 Full FIFO, valid_i held 300 cycles -> overflow_o=1, drop_cnt_o=255 saturated; err_clr_i pulse -> both 0 next cycle, contents intact.
REQ-035 FALL_THROUGH=1, empty, valid_i=ready_i=1 data_i=0x5C -> valid_o=1, data_o=0x5C same cycle, elements_o stays 0.
REQ-036 Two words stored, clr_i with simultaneous push 0x77 -> elements_o=0, valid_o=0 next cycle, drop_cnt_o unchanged.
REQ-037 rst_ni asserted asynchronously mid-stream (elements_o=2) -> elements_o=0, ready_o=1, valid_o=0 before next clock edge.

Source files
------------

// File: rtl/spi_fifo_pkg.sv
// Shared constants and helpers for the SPI stream FIFO slice.
package spi_fifo_pkg;

    // Width of the saturating dropped-push counter.
    localparam int unsigned DROP_CNT_W = 8;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_fifo_ptr.sv
// Wrapping FIFO pointer: counts 0..DEPTH-1 and wraps to 0.
module spi_fifo_ptr
    import spi_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             advance_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_q;

    // Next pointer: flush wins, otherwise step with wrap at DEPTH-1.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (advance_i) begin
            if (ptr_q == PTR_W'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/spi_stream_fifo.sv
// Valid/ready stream FIFO with optional empty bypass, watermarks and
// sticky overflow / saturating drop accounting.
module spi_stream_fifo
    import spi_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BUFFER_DEPTH     = 4,
    parameter int unsigned FALL_THROUGH     = 0,
    parameter int unsigned LOG_BUFFER_DEPTH = clog2(BUFFER_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    output logic                        ready_o,
    output logic                        valid_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    input  logic                        ready_i,
    output logic [LOG_BUFFER_DEPTH:0]   elements_o,
    input  logic [LOG_BUFFER_DEPTH:0]   afull_thr_i,
    input  logic [LOG_BUFFER_DEPTH:0]   aempty_thr_i,
    output logic                        almost_full_o,
    output logic                        almost_empty_o,
    output logic                        overflow_o,
    output logic [DROP_CNT_W-1:0]       drop_cnt_o,
    input  logic                        err_clr_i
);

    localparam int unsigned CNT_W = LOG_BUFFER_DEPTH + 1;
    localparam logic        FT_EN = (FALL_THROUGH != 0);

    logic [CNT_W-1:0]            count_d;
    logic [CNT_W-1:0]            count_q;
    logic                        overflow_d;
    logic                        overflow_q;
    logic [DROP_CNT_W-1:0]       drop_cnt_d;
    logic [DROP_CNT_W-1:0]       drop_cnt_q;
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
    logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];

    logic empty;
    logic push;
    logic pop;
    logic bypass;
    logic store;
    logic unload;
    logic drop;

    assign empty   = (count_q == '0);
    assign ready_o = (count_q != CNT_W'(BUFFER_DEPTH));
    assign valid_o = !empty || (FT_EN && valid_i);
    assign data_o  = empty ? data_i : mem_q[rd_ptr];

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;
    assign drop = valid_i && !ready_o;

    // A word that enters and leaves an empty FIFO in one cycle never touches
    // storage, so it is stripped from the store/unload terms.
    assign bypass = FT_EN && empty && push && pop;
    assign store  = push && !bypass;
    assign unload = pop && !bypass;

    spi_fifo_ptr #(
        .DEPTH (BUFFER_DEPTH),
        .PTR_W (LOG_BUFFER_DEPTH)
    ) u_wr_ptr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr_i),
        .advance_i (store),
        .ptr_o     (wr_ptr)
    );

    spi_fifo_ptr #(
        .DEPTH (BUFFER_DEPTH),
        .PTR_W (LOG_BUFFER_DEPTH)
    ) u_rd_ptr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr_i),
        .advance_i (unload),
        .ptr_o     (rd_ptr)
    );

    // Next occupancy: flush wins, simultaneous store/unload cancel out.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (store && !unload) begin
            count_d = count_q + CNT_W'(1);
        end else if (unload && !store) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Next error state: clear wins over a same-cycle drop; counter saturates.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (err_clr_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    // Occupancy and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage write port; left unreset so it can map onto RAM.
    always_ff @(posedge clk_i) begin
        if (store && !clr_i) begin
            mem_q[wr_ptr] <= data_i;
        end
    end

    assign elements_o     = count_q;
    assign almost_full_o  = (count_q >= afull_thr_i);
    assign almost_empty_o = (count_q <= aempty_thr_i);
    assign overflow_o     = overflow_q;
    assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_spi_stream_fifo.sv
// Directed bench for spi_stream_fifo: DATA_WIDTH=8, BUFFER_DEPTH=3,
// one instance without and one with fall-through.
module tb_spi_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       clr0, valid0, ready0, err0;
    logic [7:0] d0;
    logic       rdy_o0, vld_o0, af0, ae0, ovf0;
    logic [7:0] q0, drop0;
    logic [2:0] el0;

    logic       clr1, valid1, ready1, err1;
    logic [7:0] d1;
    logic       rdy_o1, vld_o1, af1, ae1, ovf1;
    logic [7:0] q1, drop1;
    logic [2:0] el1;

    logic [2:0] afull_thr  = 3'd2;
    logic [2:0] aempty_thr = 3'd0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_stream_fifo #(
        .DATA_WIDTH   (8),
        .BUFFER_DEPTH (3),
        .FALL_THROUGH (0)
    ) u_dut0 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (clr0),
        .valid_i        (valid0),
        .data_i         (d0),
        .ready_o        (rdy_o0),
        .valid_o        (vld_o0),
        .data_o         (q0),
        .ready_i        (ready0),
        .elements_o     (el0),
        .afull_thr_i    (afull_thr),
        .aempty_thr_i   (aempty_thr),
        .almost_full_o  (af0),
        .almost_empty_o (ae0),
        .overflow_o     (ovf0),
        .drop_cnt_o     (drop0),
        .err_clr_i      (err0)
    );

    spi_stream_fifo #(
        .DATA_WIDTH   (8),
        .BUFFER_DEPTH (3),
        .FALL_THROUGH (1)
    ) u_dut1 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clr_i          (clr1),
        .valid_i        (valid1),
        .data_i         (d1),
        .ready_o        (rdy_o1),
        .valid_o        (vld_o1),
        .data_o         (q1),
        .ready_i        (ready1),
        .elements_o     (el1),
        .afull_thr_i    (afull_thr),
        .aempty_thr_i   (aempty_thr),
        .almost_full_o  (af1),
        .almost_empty_o (ae1),
        .overflow_o     (ovf1),
        .drop_cnt_o     (drop1),
        .err_clr_i      (err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        clr0 = 0; valid0 = 0; ready0 = 0; err0 = 0; d0 = '0;
        clr1 = 0; valid1 = 0; ready1 = 0; err1 = 0; d1 = '0;
        #2;
        // reset state
        chk("rst_el",     32'(el0),    0);
        chk("rst_ready",  32'(rdy_o0), 1);
        chk("rst_valid",  32'(vld_o0), 0);
        chk("rst_afull",  32'(af0),    0);
        chk("rst_aempty", 32'(ae0),    1);
        chk("rst_ovf",    32'(ovf0),   0);
        chk("rst_drop",   32'(drop0),  0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // fill to full then drain
        valid0 = 1; d0 = 8'hA1; tick();
        chk("fill1_el", 32'(el0), 1);
        chk("fill1_aempty", 32'(ae0), 0);
        d0 = 8'hA2; tick();
        chk("fill2_el", 32'(el0), 2);
        chk("fill2_afull", 32'(af0), 1);
        d0 = 8'hA3; tick();
        valid0 = 0;
        chk("full_el", 32'(el0), 3);
        chk("full_ready", 32'(rdy_o0), 0);
        chk("full_afull", 32'(af0), 1);
        chk("head_a1", 32'(q0), 32'hA1);
        ready0 = 1; tick();
        chk("pop1_el", 32'(el0), 2);
        chk("pop1_ready", 32'(rdy_o0), 1);
        chk("head_a2", 32'(q0), 32'hA2);
        tick();
        chk("pop2_el", 32'(el0), 1);
        chk("head_a3", 32'(q0), 32'hA3);
        tick();
        chk("pop3_el", 32'(el0), 0);
        chk("pop3_valid", 32'(vld_o0), 0);
        chk("pop3_aempty", 32'(ae0), 1);

        // streaming across pointer wrap
        for (int i = 0; i < 6; i++) begin
            valid0 = (i < 5);
            d0 = 8'(8'h10 + i);
            #1;
            if (i > 0) chk("stream_data", 32'(q0), 32'(8'h10 + i - 1));
            tick();
            chk("stream_el", 32'(el0), (i < 5) ? 1 : 0);
        end
        valid0 = 0; ready0 = 0;

        // flush with concurrent push
        valid0 = 1; d0 = 8'h21; tick();
        d0 = 8'h22; tick();
        chk("preclr_el", 32'(el0), 2);
        clr0 = 1; d0 = 8'h77; tick();
        clr0 = 0; valid0 = 0;
        chk("clr_el", 32'(el0), 0);
        chk("clr_valid", 32'(vld_o0), 0);
        chk("clr_drop", 32'(drop0), 0);

        // overflow, saturation, error clear
        valid0 = 1; d0 = 8'h31; tick();
        d0 = 8'h32; tick();
        d0 = 8'h33; tick();
        d0 = 8'hEE; tick();
        chk("ovf_first", 32'(ovf0), 1);
        chk("drop_first", 32'(drop0), 1);
        repeat (299) tick();
        chk("ovf_sticky", 32'(ovf0), 1);
        chk("drop_sat", 32'(drop0), 255);
        err0 = 1; tick();
        err0 = 0; valid0 = 0;
        chk("errclr_ovf", 32'(ovf0), 0);
        chk("errclr_drop", 32'(drop0), 0);
        chk("errclr_el", 32'(el0), 3);
        chk("keep_31", 32'(q0), 32'h31);
        ready0 = 1; tick();
        chk("keep_32", 32'(q0), 32'h32);
        tick();
        chk("keep_33", 32'(q0), 32'h33);
        tick();
        chk("drain_el", 32'(el0), 0);
        ready0 = 0;

        // asynchronous reset mid-stream
        valid0 = 1; d0 = 8'h41; tick();
        d0 = 8'h42; tick();
        valid0 = 0;
        chk("prerst_el", 32'(el0), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_el", 32'(el0), 0);
        chk("arst_ready", 32'(rdy_o0), 1);
        chk("arst_valid", 32'(vld_o0), 0);
        #1 rst_n = 1'b1;

        // fall-through instance: bypass on empty
        tick();
        valid1 = 1; ready1 = 1; d1 = 8'h5C;
        #1;
        chk("ft_valid", 32'(vld_o1), 1);
        chk("ft_data", 32'(q1), 32'h5C);
        tick();
        chk("ft_el", 32'(el1), 0);
        chk("ft_ovf", 32'(ovf1), 0);
        ready1 = 0; d1 = 8'h66; tick();
        valid1 = 0;
        chk("ft_store_el", 32'(el1), 1);
        chk("ft_store_data", 32'(q1), 32'h66);
        ready1 = 1; tick();
        ready1 = 0;
        chk("ft_drain_el", 32'(el1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
